// File: rtl/byte_lane_data_mem.sv
// Byte-lane data memory for the MIPS MEM stage.
// Handles big-endian byte/half/word loads and stores through a req/resp
// handshake with one outstanding request and a configurable load latency.
// Misaligned, out-of-range and reserved-size accesses answer with err and
// leave memory untouched.
module byte_lane_data_mem #(
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            rdy_q;
  logic [31:0]     hold_d;

  // lane 3 holds bits [31:24] = byte offset 0 (big-endian)
  logic [3:0][7:0] mem [DEPTH];

  logic [IW-1:0]   idx;
  logic [1:0]      off;
  logic            oor, misal, err, accept;
  logic [3:0]      be;
  logic [3:0][7:0] lane_wd;
  logic [3:0][7:0] rword;
  logic [7:0]      bsel;
  logic [15:0]     hsel;
  logic [31:0]     ld_data;

  assign idx    = req_addr[IW+1:2];
  assign off    = req_addr[1:0];
  assign oor    = |(req_addr >> (IW + 2));
  // reset blocks acceptance so nothing commits during the reset cycle
  assign req_ready = rdy_q & ~reset;
  assign accept = req_valid & req_ready;
  assign err    = oor | misal | (req_size == 2'b11);

  // alignment check and per-lane write enables from size/offset
  always_comb begin
    misal = 1'b0;
    be    = 4'b0000;
    case (req_size)
      2'b00: be = 4'b1000 >> off;
      2'b01: begin
        misal = off[0];
        be    = off[1] ? 4'b0011 : 4'b1100;
      end
      2'b10: begin
        misal = |off;
        be    = 4'b1111;
      end
      default: be = 4'b0000;
    endcase
  end

  // sub-word stores replicate the right-justified data across lanes
  for (genvar l = 0; l < 4; l++) begin : g_lane
    assign lane_wd[l] = (req_size == 2'b00) ? req_wdata[7:0] :
                        (req_size == 2'b01) ? ((l % 2 == 1) ? req_wdata[15:8] : req_wdata[7:0]) :
                                              req_wdata[8*l +: 8];
  end

  // load extraction and extension; stores and errors return zero
  always_comb begin
    rword   = mem[idx];
    bsel    = rword[~off];
    hsel    = off[1] ? {rword[1], rword[0]} : {rword[3], rword[2]};
    case (req_size)
      2'b00:   ld_data = req_signed ? {{24{bsel[7]}}, bsel} : {24'h0, bsel};
      2'b01:   ld_data = req_signed ? {{16{hsel[15]}}, hsel} : {16'h0, hsel};
      default: ld_data = rword;
    endcase
    if (err || req_we) ld_data = 32'h0;
  end

  // store commit on the accept edge, selected lanes only
  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int l = 0; l < 4; l++)
        if (be[l]) mem[idx][l] <= lane_wd[l];
    end
  end

  // request/response FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rdy_q      <= 1'b1;
      hold_d     <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          rdy_q  <= 1'b0;
          hold_d <= ld_data;
          if (req_we || err || READ_LAT == 1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= ld_data;
            resp_err   <= err;
          end else begin
            state <= WAIT;
            cnt   <= CW'(READ_LAT - 1);
          end
        end
        WAIT: begin
          // only error-free loads wait, so err is always 0 here
          if (cnt == CW'(1)) begin
            state      <= RESP;
            cnt        <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= hold_d;
            resp_err   <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          state      <= IDLE;
          rdy_q      <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_lane_data_mem.sv
// Bench for byte_lane_data_mem: directed scenarios plus randomized traffic
// checked against a byte-array reference model.
module tb_byte_lane_data_mem;

  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int LAT   = 3;
  localparam int NB    = DEPTH * 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mm [NB];

  byte_lane_data_mem #(.ADDR_W(AW), .DEPTH(DEPTH), .READ_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
           (a >= 32'(NB));
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int i = int'(a);
    logic [31:0] v;
    case (sz)
      2'b00: begin
        v = {24'h0, mm[i]};
        if (sg && mm[i][7]) v = v | 32'hFFFFFF00;
      end
      2'b01: begin
        v = {16'h0, mm[i], mm[i+1]};
        if (sg && mm[i][7]) v = v | 32'hFFFF0000;
      end
      default: v = {mm[i], mm[i+1], mm[i+2], mm[i+3]};
    endcase
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int i = int'(a);
    case (sz)
      2'b00: mm[i] = wd[7:0];
      2'b01: begin mm[i] = wd[15:8]; mm[i+1] = wd[7:0]; end
      default: begin
        mm[i] = wd[31:24]; mm[i+1] = wd[23:16]; mm[i+2] = wd[15:8]; mm[i+3] = wd[7:0];
      end
    endcase
  endtask

  // one request: call and return at a negedge; busy_junk drives ignored requests while busy
  task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic busy_junk,
                        output logic [31:0] rd);
    logic        e_err;
    logic [31:0] e_d;
    int          e_lat, lat, w;
    e_err = model_err(sz, a);
    e_d   = (we || e_err) ? 32'h0 : model_load(sz, sg, a);
    e_lat = (we || e_err) ? 1 : LAT;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    chk({tag, "/ready"}, 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    if (we && !e_err) model_store(sz, a, wd);
    @(negedge clk);
    req_valid = busy_junk; req_we = 1'b1; req_size = 2'b10;
    req_addr = 32'($urandom_range(0, DEPTH - 1) * 4); req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    req_valid = 1'b0;
    rd = resp_rdata;
    chk({tag, "/lat"}, 32'(lat), 32'(e_lat));
    chk({tag, "/rdata"}, resp_rdata, e_d);
    chk({tag, "/err"}, 32'(resp_err), 32'(e_err));
    @(negedge clk);
    chk({tag, "/idle"}, {resp_valid, resp_err, resp_rdata[29:0]}, 32'h0);
  endtask

  logic [31:0] rd;
  int seen;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    chk("rst/ready", 32'(req_ready), 32'h0);
    chk("rst/resp", {resp_valid, resp_err, resp_rdata[29:0]}, 32'h0);
    chk("rst/rdata", resp_rdata, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst/ready_after", 32'(req_ready), 32'h1);
    @(negedge clk);

    // give every word a known value
    for (int i = 0; i < DEPTH; i++)
      access("init", 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, 1'b0, rd);

    // word store/load round trip
    access("t1/st", 1'b1, 2'b10, 1'b0, 32'h10, 32'hA1B2C3D4, 1'b0, rd);
    access("t1/ld", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd);
    chk("t1/const", rd, 32'hA1B2C3D4);
    // byte store and byte loads
    access("t2/st", 1'b1, 2'b00, 1'b0, 32'h12, 32'h00000055, 1'b0, rd);
    access("t2/ldw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd);
    chk("t2/w_const", rd, 32'hA1B255D4);
    access("t2/ldbu", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, rd);
    chk("t2/bu_const", rd, 32'h000000A1);
    access("t2/ldbs", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, rd);
    chk("t2/bs_const", rd, 32'hFFFFFFA1);
    // half loads/stores
    access("t3/ldh", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, rd);
    chk("t3/h_const", rd, 32'h000055D4);
    access("t3/sth", 1'b1, 2'b01, 1'b0, 32'h10, 32'h00008001, 1'b0, rd);
    access("t3/ldhs", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, rd);
    chk("t3/hs_const", rd, 32'hFFFF8001);
    // error cases must not change memory
    access("t4/ldw_mis", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b0, rd);
    access("t4/sth_mis", 1'b1, 2'b01, 1'b0, 32'h13, 32'h0000FFFF, 1'b0, rd);
    access("t4/sz11", 1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0, rd);
    access("t4/ldw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd);
    chk("t4/w_const", rd, 32'h800155D4);
    // out of range and top word
    access("t5/oor_st", 1'b1, 2'b10, 1'b0, 32'h50, 32'hDEADBEEF, 1'b0, rd);
    access("t5/oor_ld", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, rd);
    access("t5/ld10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd);
    chk("t5/noalias", rd, 32'h800155D4);
    access("t5/st_top", 1'b1, 2'b10, 1'b0, 32'(NB - 4), 32'h13572468, 1'b0, rd);
    access("t5/st_w0", 1'b1, 2'b10, 1'b0, 32'h0, 32'h9ABCDEF0, 1'b0, rd);
    access("t5/ld_top", 1'b0, 2'b10, 1'b0, 32'(NB - 4), 32'h0, 1'b0, rd);
    chk("t5/top_const", rd, 32'h13572468);

    // reset while a load waits: its response is dropped
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6/ready_in_rst", 32'(req_ready), 32'h0);
    seen = int'(resp_valid);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (resp_valid) seen++;
      @(negedge clk);
    end
    chk("t6/noresp", 32'(seen), 32'h0);
    chk("t6/ready", 32'(req_ready), 32'h1);
    access("t6/ld", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd);
    chk("t6/intact", rd, 32'h800155D4);

    // randomized traffic, with ignored requests driven while busy
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, NB - 1));
      if ($urandom_range(0, 7) == 0) a = a | (32'h40 << $urandom_range(0, 25));
      access("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, 1'($urandom_range(0, 1)), rd);
    end
    // final sweep of every word against the model
    for (int i = 0; i < DEPTH; i++)
      access("sweep", 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0, 1'b0, rd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
